// File: rtl/fell_stim_checker_if.sv
// Purpose : host-side bundle for fell_stim_checker (vector load, run control, results).
// Latency : plain wires, no storage.
// Backpress: none; the host must only load/start while busy is low.
// Ports    : ld_valid/ld_addr/ld_a/ld_b load a slot, start/len/abort control a run,
//            a_out/b_out replay vectors, busy/done and the counters report results.
interface fell_stim_checker_if #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             ld_valid;
  logic [AW-1:0]    ld_addr;
  logic             ld_a;
  logic             ld_b;
  logic             start;
  logic [AW:0]      len;
  logic             abort;
  logic             a_out;
  logic             b_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] vac_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic             fail_seen;
  logic [AW-1:0]    first_fail_idx;

  // Host side: drives load/control, observes replay and results.
  modport master (
    output ld_valid, ld_addr, ld_a, ld_b, start, len, abort,
    input  a_out, b_out, busy, done, pass_cnt, vac_cnt, fail_cnt,
           fail_seen, first_fail_idx
  );

  // Checker side.
  modport slave (
    input  ld_valid, ld_addr, ld_a, ld_b, start, len, abort,
    output a_out, b_out, busy, done, pass_cnt, vac_cnt, fail_cnt,
           fail_seen, first_fail_idx
  );
endinterface

// File: rtl/fell_stim_checker.sv
// Purpose : replays up to DEPTH (a,b) vectors and scores "a |-> $fell(b)" per cycle.
// Latency : first vector on a_out/b_out one cycle after start; each vector scored one cycle later.
// Backpress: none; loads and starts outside IDLE are dropped, abort ends a run unscored.
// Ports    : clk, rst_n (async active-low), bus (slave modport of fell_stim_checker_if).
//            Counters saturate; results hold until the next accepted start or reset.
module fell_stim_checker #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fell_stim_checker_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       mem_q [DEPTH];
  logic [1:0]       mem_d [DEPTH];
  logic [AW-1:0]    idx_q, idx_d;
  logic [LW-1:0]    len_q, len_d;
  logic             a_out_q, a_out_d;
  logic             b_out_q, b_out_d;
  logic             b_prev_q, b_prev_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] vac_cnt_q, vac_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic             fail_seen_q, fail_seen_d;
  logic [AW-1:0]    ffi_q, ffi_d;
  logic [AW-1:0]    idx_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign idx_nxt = idx_q + AW'(1);

  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    idx_d       = idx_q;
    len_d       = len_q;
    a_out_d     = a_out_q;
    b_out_d     = b_out_q;
    b_prev_d    = b_prev_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_cnt_d  = pass_cnt_q;
    vac_cnt_d   = vac_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    fail_seen_d = fail_seen_q;
    ffi_d       = ffi_q;

    case (state_q)
      S_IDLE: begin
        if (bus.ld_valid) mem_d[bus.ld_addr] = {bus.ld_a, bus.ld_b};
        if (bus.start && (bus.len != '0)) begin
          state_d     = S_RUN;
          len_d       = (bus.len > LW'(DEPTH)) ? LW'(DEPTH) : bus.len;
          idx_d       = '0;
          pass_cnt_d  = '0;
          vac_cnt_d   = '0;
          fail_cnt_d  = '0;
          fail_seen_d = 1'b0;
          ffi_d       = '0;
          b_prev_d    = 1'b0;
          // Slot 0 is read before this edge's load lands.
          a_out_d     = mem_q[0][1];
          b_out_d     = mem_q[0][0];
          busy_d      = 1'b1;
        end
      end

      S_RUN: begin
        if (bus.abort) begin
          // Vector currently on the outputs is dropped unscored.
          state_d = S_IDLE;
          a_out_d = 1'b0;
          b_out_d = 1'b0;
          busy_d  = 1'b0;
        end else begin
          if (!a_out_q) begin
            pass_cnt_d = sat_inc(pass_cnt_q);
            vac_cnt_d  = sat_inc(vac_cnt_q);
          end else if (b_prev_q && !b_out_q) begin
            pass_cnt_d = sat_inc(pass_cnt_q);
          end else begin
            fail_cnt_d = sat_inc(fail_cnt_q);
            if (!fail_seen_q) begin
              fail_seen_d = 1'b1;
              ffi_d       = idx_q;
            end
          end
          b_prev_d = b_out_q;

          if ({1'b0, idx_q} == len_q - LW'(1)) begin
            state_d = S_DONE;
            a_out_d = 1'b0;
            b_out_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_nxt;
            a_out_d = mem_q[idx_nxt][1];
            b_out_d = mem_q[idx_nxt][0];
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      a_out_q     <= 1'b0;
      b_out_q     <= 1'b0;
      b_prev_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_cnt_q  <= '0;
      vac_cnt_q   <= '0;
      fail_cnt_q  <= '0;
      fail_seen_q <= 1'b0;
      ffi_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      a_out_q     <= a_out_d;
      b_out_q     <= b_out_d;
      b_prev_q    <= b_prev_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_cnt_q  <= pass_cnt_d;
      vac_cnt_q   <= vac_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      fail_seen_q <= fail_seen_d;
      ffi_q       <= ffi_d;
    end
  end

  assign bus.a_out          = a_out_q;
  assign bus.b_out          = b_out_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass_cnt       = pass_cnt_q;
  assign bus.vac_cnt        = vac_cnt_q;
  assign bus.fail_cnt       = fail_cnt_q;
  assign bus.fail_seen      = fail_seen_q;
  assign bus.first_fail_idx = ffi_q;
endmodule

// File: tb/tb_fell_stim_checker.sv
// Purpose : directed bench for fell_stim_checker (main instance CNT_W=8, second with CNT_W=2).
// Latency : inputs driven on negedges, outputs sampled on negedges.
// Backpress: n/a.
module tb_fell_stim_checker;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vec_n = 0;
  int   err_n = 0;

  fell_stim_checker_if #(.DEPTH(8), .CNT_W(8)) bus ();
  fell_stim_checker_if #(.DEPTH(8), .CNT_W(2)) bus2 ();

  fell_stim_checker #(.DEPTH(8), .CNT_W(8)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  fell_stim_checker #(.DEPTH(8), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Packed view of the main instance results: pass, vac, fail, fail_seen, first_fail_idx.
  function automatic logic [27:0] res();
    return {bus.pass_cnt, bus.vac_cnt, bus.fail_cnt, bus.fail_seen, bus.first_fail_idx};
  endfunction

  function automatic logic [3:0] io();
    return {bus.a_out, bus.b_out, bus.busy, bus.done};
  endfunction

  // All tasks begin and end just after a negedge.
  task automatic load(input logic [2:0] addr, input logic a, input logic b);
    bus.ld_valid = 1'b1; bus.ld_addr = addr; bus.ld_a = a; bus.ld_b = b;
    @(negedge clk);
    bus.ld_valid = 1'b0;
  endtask

  task automatic start_run(input logic [3:0] n);
    bus.start = 1'b1; bus.len = n;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Expects n vectors (bit k of va/vb) on consecutive cycles, then one done cycle.
  task automatic play_check(input string name, input logic [7:0] va, input logic [7:0] vb,
                            input int n);
    for (int k = 0; k < n; k++) begin
      vec_n++;
      if (io() !== {va[k], vb[k], 1'b1, 1'b0}) begin
        $display("FAIL %s play k=%0d: got a,b,busy,done=%b required %b", name, k, io(),
                 {va[k], vb[k], 1'b1, 1'b0});
        err_n++;
      end
      @(negedge clk);
    end
    vec_n++;
    if (io() !== 4'b0001) begin
      $display("FAIL %s done cycle: got a,b,busy,done=%b required 0001", name, io());
      err_n++;
    end
    @(negedge clk);
    vec_n++;
    if (io() !== 4'b0000) begin
      $display("FAIL %s after done: got a,b,busy,done=%b required 0000", name, io());
      err_n++;
    end
  endtask

  task automatic check_res(input string name, input logic [27:0] exp);
    vec_n++;
    if (res() !== exp) begin
      $display("FAIL %s results: got pass=%0d vac=%0d fail=%0d seen=%0d ffi=%0d required pass=%0d vac=%0d fail=%0d seen=%0d ffi=%0d",
               name, res()[27:20], res()[19:12], res()[11:4], res()[3], res()[2:0],
               exp[27:20], exp[19:12], exp[11:4], exp[3], exp[2:0]);
      err_n++;
    end
  endtask

  task automatic test_reset();
    #2;
    vec_n++;
    if ({io(), res()} !== 32'd0) begin
      $display("FAIL reset_during: got %h required 0", {io(), res()});
      err_n++;
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vec_n++;
    if ({io(), res(), bus2.fail_cnt} !== 34'd0) begin
      $display("FAIL reset_after: got %h required 0", {io(), res(), bus2.fail_cnt});
      err_n++;
    end
  endtask

  // (0,1),(1,0),(1,1),(0,0),(1,1): vac, pass, fail, vac, fail.
  task automatic test_basic();
    load(0, 0, 1); load(1, 1, 0); load(2, 1, 1); load(3, 0, 0); load(4, 1, 1);
    start_run(5);
    play_check("basic", 8'b0001_0110, 8'b0001_0101, 5);
    check_res("basic", {8'd3, 8'd2, 8'd2, 1'b1, 3'd2});
  endtask

  task automatic test_pass_only();
    load(0, 0, 1); load(1, 1, 0);
    start_run(2);
    play_check("pass_only", 8'b0000_0010, 8'b0000_0001, 2);
    check_res("pass_only", {8'd2, 8'd1, 8'd0, 1'b0, 3'd0});
  endtask

  // b_prev starts at 0, so (1,0) as the first vector is a failure, scored one cycle late.
  task automatic test_first_vec();
    load(0, 1, 0);
    start_run(1);
    vec_n++;
    if ({io(), bus.fail_cnt} !== {4'b1010, 8'd0}) begin
      $display("FAIL first_vec cycle0: got %h required %h", {io(), bus.fail_cnt}, {4'b1010, 8'd0});
      err_n++;
    end
    @(negedge clk);
    vec_n++;
    if ({io(), bus.fail_cnt} !== {4'b0001, 8'd1}) begin
      $display("FAIL first_vec done: got %h required %h", {io(), bus.fail_cnt}, {4'b0001, 8'd1});
      err_n++;
    end
    @(negedge clk);
    check_res("first_vec", {8'd0, 8'd0, 8'd1, 1'b1, 3'd0});
  endtask

  // (0,0),(1,0),(0,1),(1,1),(0,1),(1,0),(0,0),(1,1): len 12 clamps to 8.
  task automatic test_len_clamp();
    logic [7:0] va;
    logic [7:0] vb;
    va = 8'b1010_1010;
    vb = 8'b1001_1100;
    for (int i = 0; i < 8; i++) load(3'(i), va[i], vb[i]);
    start_run(4'd12);
    play_check("len_clamp", va, vb, 8);
    check_res("len_clamp", {8'd5, 8'd4, 8'd3, 1'b1, 3'd1});
    start_run(4'd0);
    vec_n++;
    if (io() !== 4'b0000) begin
      $display("FAIL len_zero: got a,b,busy,done=%b required 0000", io());
      err_n++;
    end
    @(negedge clk);
    vec_n++;
    if (io() !== 4'b0000) begin
      $display("FAIL len_zero later: got a,b,busy,done=%b required 0000", io());
      err_n++;
    end
    check_res("len_zero", {8'd5, 8'd4, 8'd3, 1'b1, 3'd1});
  endtask

  task automatic test_abort();
    int dones;
    load(0, 0, 1); load(1, 1, 0); load(2, 1, 1); load(3, 0, 0); load(4, 1, 1);
    start_run(5);
    // Cycle 0: try to overwrite slot 0 with (1,1) while running.
    bus.ld_valid = 1'b1; bus.ld_addr = 3'd0; bus.ld_a = 1'b1; bus.ld_b = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vec_n++;
    if (io() !== 4'b1110) begin
      $display("FAIL abort cycle2: got a,b,busy,done=%b required 1110", io());
      err_n++;
    end
    bus.ld_valid = 1'b0;
    bus.abort    = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    vec_n++;
    if (io() !== 4'b0000) begin
      $display("FAIL abort idle: got a,b,busy,done=%b required 0000", io());
      err_n++;
    end
    check_res("abort", {8'd2, 8'd1, 8'd0, 1'b0, 3'd0});
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.done) dones++;
      @(negedge clk);
    end
    vec_n++;
    if (dones !== 0) begin
      $display("FAIL abort no_done: got %0d done cycles required 0", dones);
      err_n++;
    end
    start_run(5);
    play_check("abort_replay", 8'b0001_0110, 8'b0001_0101, 5);
    check_res("abort_replay", {8'd3, 8'd2, 8'd2, 1'b1, 3'd2});
  endtask

  task automatic test_saturate();
    int waited;
    for (int i = 0; i < 8; i++) begin
      bus2.ld_valid = 1'b1; bus2.ld_addr = 3'(i); bus2.ld_a = 1'b1; bus2.ld_b = 1'b1;
      @(negedge clk);
    end
    bus2.ld_valid = 1'b0;
    bus2.start = 1'b1; bus2.len = 4'd8;
    @(negedge clk);
    bus2.start = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge clk);
    vec_n++;
    if ({bus2.busy, bus2.fail_cnt} !== {1'b1, 2'd3}) begin
      $display("FAIL sat mid: got busy,fail=%b required 111", {bus2.busy, bus2.fail_cnt});
      err_n++;
    end
    waited = 0;
    while (!bus2.done && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    vec_n++;
    if (!bus2.done) begin
      $display("FAIL sat done_timeout: got done=0 required 1");
      err_n++;
    end
    vec_n++;
    if ({bus2.pass_cnt, bus2.vac_cnt, bus2.fail_cnt, bus2.fail_seen, bus2.first_fail_idx}
        !== {2'd0, 2'd0, 2'd3, 1'b1, 3'd0}) begin
      $display("FAIL sat final: got %b required %b",
               {bus2.pass_cnt, bus2.vac_cnt, bus2.fail_cnt, bus2.fail_seen, bus2.first_fail_idx},
               {2'd0, 2'd0, 2'd3, 1'b1, 3'd0});
      err_n++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    start_run(8);
    @(negedge clk); @(negedge clk); @(negedge clk);
    // Scored so far: (0,1) vac, (1,0) pass, (1,1) fail.
    vec_n++;
    if ({bus.busy, bus.pass_cnt, bus.fail_cnt} !== {1'b1, 8'd2, 8'd1}) begin
      $display("FAIL mid_run pre_reset: got %h required %h",
               {bus.busy, bus.pass_cnt, bus.fail_cnt}, {1'b1, 8'd2, 8'd1});
      err_n++;
    end
    #1 rst_n = 1'b0;
    #1;
    vec_n++;
    if ({io(), res(), bus2.fail_cnt, bus2.fail_seen} !== 35'd0) begin
      $display("FAIL mid_run async_reset: got %h required 0",
               {io(), res(), bus2.fail_cnt, bus2.fail_seen});
      err_n++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // Memory was cleared: every slot now plays as (0,0).
    start_run(8);
    play_check("post_reset", 8'h00, 8'h00, 8);
    check_res("post_reset", {8'd8, 8'd8, 8'd0, 1'b0, 3'd0});
  endtask

  initial begin
    bus.ld_valid  = 1'b0; bus.ld_addr  = '0; bus.ld_a  = 1'b0; bus.ld_b  = 1'b0;
    bus.start     = 1'b0; bus.len      = '0; bus.abort = 1'b0;
    bus2.ld_valid = 1'b0; bus2.ld_addr = '0; bus2.ld_a = 1'b0; bus2.ld_b = 1'b0;
    bus2.start    = 1'b0; bus2.len     = '0; bus2.abort = 1'b0;
    test_reset();
    test_basic();
    test_pass_only();
    test_first_vec();
    test_len_clamp();
    test_abort();
    test_saturate();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
    $finish;
  end
endmodule

// File: doc/fell_stim_checker.md
Name: fell_stim_checker

Overview:
- Synthesizable stimulus sequencer plus in-hardware checker for the rule "a |-> $fell(b)".
- A host loads up to DEPTH (a,b) vectors and issues start. The block plays the vectors onto a_out/b_out one per clock and scores each cycle as pass, vacuous pass or fail. It then reports the counts and pulses done.
- Used as the self-checking companion to the SVA method benches, so assertion results can be cross-checked against RTL counters.

Parameters:
- DEPTH, 8, number of vector slots; a power of 2, at least 2.
- CNT_W, 8, width of each result counter.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- ld_valid  in  1  write one vector slot this cycle.
- ld_addr  in  $clog2(DEPTH)  slot index.
- ld_a  in  1  a value for the slot.
- ld_b  in  1  b value for the slot.
- start  in  1  begin playback; sampled only in IDLE.
- len  in  $clog2(DEPTH)+1  number of vectors to play.
- abort  in  1  synchronous abort.
- a_out  out  1  driven a.
- b_out  out  1  driven b.
- busy  out  1  high in RUN.
- done  out  1  one-cycle completion pulse.
- pass_cnt  out  CNT_W  passes, vacuous passes included.
- vac_cnt  out  CNT_W  vacuous passes (a==0).
- fail_cnt  out  CNT_W  failures.
- fail_seen  out  1  at least one failure in this run.
- first_fail_idx  out  $clog2(DEPTH)  index of the first failing vector.

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0. Vector memory cleared to 0. Internal b_prev=0, idx=0.
- Load: when ld_valid=1 and state is IDLE, mem[ld_addr] <= {ld_a,ld_b} at the clock edge. ld_valid outside IDLE is ignored.
- Same-cycle load and start: the load is performed, but the run uses pre-edge memory contents for slot 0 only if ld_addr==0. Benches must not rely on this case; it is defined as "load wins for later slots".
- State IDLE:
  - start=1 with len!=0 → RUN. Capture L=min(len,DEPTH). idx=0. Clear all counters, fail_seen and first_fail_idx. b_prev=0.
  - start with len==0 is ignored.
- State RUN:
  - During run cycle k (k=0..L-1), a_out/b_out = mem[k] (registered outputs). busy=1.
  - At the edge closing cycle k, vector k is scored with cur=(a_out,b_out):
    - a=0: vacuous. pass_cnt+1, vac_cnt+1.
    - a=1 and b_prev=1 and b=0: pass. pass_cnt+1.
    - a=1 otherwise: fail. fail_cnt+1. If fail_seen=0, set first_fail_idx=k and fail_seen=1.
    - Then b_prev <= b.
  - Scoring latency: one cycle after a vector appears on the outputs.
  - Counters saturate at 2^CNT_W-1 and never wrap.
  - After scoring k=L-1 → DONE. a_out/b_out return to 0.
- State DONE: done=1 and busy=0 for exactly one cycle, then IDLE. Results hold until the next accepted start or reset.
- abort=1 in RUN → IDLE at the next edge.
  - a_out/b_out go to 0, no done pulse.
  - The vector on the outputs in the abort cycle is not scored.
  - Counters keep their partial values.
  - abort is ignored in IDLE and DONE.
- start during RUN or DONE is ignored.
- Reset mid-run: immediate return to the reset state. Memory contents are lost.

Test Plan:
- Load (a,b)=(0,1),(1,0),(1,1),(0,0),(1,1) into slots 0-4, start with len=5 → a_out/b_out follow those vectors on 5 consecutive cycles, busy=1 for those 5 cycles, done pulses on the 6th cycle. Final pass_cnt=3, vac_cnt=2, fail_cnt=2, fail_seen=1, first_fail_idx=2.
- Load slot0=(0,1), slot1=(1,0), start with len=2 → pass_cnt=2, vac_cnt=1, fail_cnt=0, fail_seen=0.
- Slot0=(1,0) with len=1 → fail_cnt=1, first_fail_idx=0. This checks that b_prev starts at 0, so no $fell on the first vector.
- Start with len=12 and DEPTH=8 → exactly 8 vectors played. A following start with len=0 → no state change, done stays low.
- Abort asserted in run cycle 2 of a 5-vector run → the state returns to IDLE, done never pulses, counters reflect exactly 2 scored vectors. ld_valid asserted during the run does not alter memory (verify by replaying).
- CNT_W=2 with all 8 vectors set to (1,1) → fail_cnt saturates at 3. Assert rst_n low during RUN → all outputs read 0 immediately, without waiting for a clock edge.
